// File: rtl/arranque_rampa_param.sv
// arranque_rampa_param: staged motor start ramp with fast/slow dwell, thermometer-coded stage level.
// Define RAMP_DOWN_SOFT_EN for a stepwise ramp down; otherwise dropping the request stops at once.
module arranque_rampa_param #(
    parameter int STEPS      = 3,
    parameter int TICK_DIV   = 100000000,
    parameter int DWELL_FAST = 1,
    parameter int DWELL_SLOW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rapido,
    input  logic             lento,
    output logic [STEPS-1:0] level,
    output logic             at_top,
    output logic             busy,
    output logic             mode_fast
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DWELL_SLOW + 1);
    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;
    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] dwell;
    logic          req, fast_req, tick, dwell_done;
    assign req        = rapido | lento;
    assign fast_req   = rapido & ~lento;
    assign tick       = tick_cnt == TW'(TICK_DIV - 1);
    assign dwell_done = tick && dwell == (mode_fast ? DW'(DWELL_FAST - 1) : DW'(DWELL_SLOW - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            level     <= '0;
            at_top    <= 1'b0;
            busy      <= 1'b0;
            mode_fast <= 1'b0;
            tick_cnt  <= '0;
            dwell     <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state     <= RAMP_UP;
                    level     <= STEPS'(1);
                    busy      <= 1'b1;
                    mode_fast <= fast_req;
                    tick_cnt  <= '0;
                    dwell     <= '0;
                end
                RAMP_UP: if (!req) begin
`ifdef RAMP_DOWN_SOFT_EN
                    state    <= RAMP_DOWN;
`else
                    state    <= IDLE;
                    level    <= '0;
                    busy     <= 1'b0;
`endif
                    tick_cnt <= '0;
                    dwell    <= '0;
                end else begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) dwell <= dwell_done ? '0 : dwell + 1'b1;
                    if (dwell_done) begin
                        level <= {level[STEPS-2:0], 1'b1};
                        // Adding the top stage enters RUN on the same edge.
                        if (level[STEPS-2]) begin
                            state  <= RUN;
                            at_top <= 1'b1;
                            busy   <= 1'b0;
                        end
                    end
                end
                RUN: if (!req) begin
                    at_top <= 1'b0;
`ifdef RAMP_DOWN_SOFT_EN
                    state  <= RAMP_DOWN;
                    busy   <= 1'b1;
`else
                    state  <= IDLE;
                    level  <= '0;
`endif
                end
                RAMP_DOWN: if (req) begin
                    state     <= RAMP_UP;
                    mode_fast <= fast_req;
                    tick_cnt  <= '0;
                    dwell     <= '0;
                end else begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) dwell <= dwell_done ? '0 : dwell + 1'b1;
                    if (dwell_done) begin
                        level <= level >> 1;
                        if (!level[1]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arranque_rampa_param.sv
// tb_arranque_rampa_param: directed checks of ramp timing, mode latching, drop/reassert and async reset.
// Observed vector is {level[2:0], at_top, busy, mode_fast}.
module tb_arranque_rampa_param;
    logic       clk = 0, reset = 1, rapido = 0, lento = 0;
    logic [2:0] level;
    logic       at_top, busy, mode_fast;
    logic [5:0] obs;
    int         tests = 0, fails = 0;

    arranque_rampa_param #(.STEPS(3), .TICK_DIV(4), .DWELL_FAST(1), .DWELL_SLOW(3)) dut (
        .clk(clk), .reset(reset), .rapido(rapido), .lento(lento),
        .level(level), .at_top(at_top), .busy(busy), .mode_fast(mode_fast)
    );

    always #5 clk = ~clk;
    assign obs = {level, at_top, busy, mode_fast};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rapido = 0;
        lento  = 0;
        reset  = 1;
        step(1);
        reset = 0;
    endtask

    task automatic test_reset;
        step(2);
        tests++; if (obs !== 6'b000_0_0_0) begin fails++; $display("FAIL reset got=%b exp=%b", obs, 6'b000_0_0_0); end
        reset = 0;
        step(2);
        tests++; if (obs !== 6'b000_0_0_0) begin fails++; $display("FAIL idle_hold got=%b exp=%b", obs, 6'b000_0_0_0); end
    endtask

    task automatic test_fast;
        rapido = 1;
        step(1);
        tests++; if (obs !== 6'b001_0_1_1) begin fails++; $display("FAIL fast_c1 got=%b exp=%b", obs, 6'b001_0_1_1); end
        step(3);
        tests++; if (obs !== 6'b001_0_1_1) begin fails++; $display("FAIL fast_c4 got=%b exp=%b", obs, 6'b001_0_1_1); end
        step(1);
        tests++; if (obs !== 6'b011_0_1_1) begin fails++; $display("FAIL fast_c5 got=%b exp=%b", obs, 6'b011_0_1_1); end
        step(4);
        tests++; if (obs !== 6'b111_1_0_1) begin fails++; $display("FAIL fast_c9 got=%b exp=%b", obs, 6'b111_1_0_1); end
        step(7);
        tests++; if (obs !== 6'b111_1_0_1) begin fails++; $display("FAIL run_hold got=%b exp=%b", obs, 6'b111_1_0_1); end
        rapido = 0;
        step(1);
`ifdef RAMP_DOWN_SOFT_EN
        tests++; if (obs !== 6'b111_0_1_1) begin fails++; $display("FAIL down_entry got=%b exp=%b", obs, 6'b111_0_1_1); end
        step(4);
        tests++; if (obs !== 6'b011_0_1_1) begin fails++; $display("FAIL down_011 got=%b exp=%b", obs, 6'b011_0_1_1); end
        step(4);
        tests++; if (obs !== 6'b001_0_1_1) begin fails++; $display("FAIL down_001 got=%b exp=%b", obs, 6'b001_0_1_1); end
        step(4);
        tests++; if (obs !== 6'b000_0_0_1) begin fails++; $display("FAIL down_idle got=%b exp=%b", obs, 6'b000_0_0_1); end
`else
        tests++; if (obs !== 6'b000_0_0_1) begin fails++; $display("FAIL stop_run got=%b exp=%b", obs, 6'b000_0_0_1); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy cycle=%0d got=%b exp=0", i, busy); end
        end
`endif
    endtask

    task automatic test_slow(input logic both);
        lento  = 1;
        rapido = both;
        step(1);
        tests++; if (obs !== 6'b001_0_1_0) begin fails++; $display("FAIL slow_c1 both=%b got=%b exp=%b", both, obs, 6'b001_0_1_0); end
        step(11);
        tests++; if (obs !== 6'b001_0_1_0) begin fails++; $display("FAIL slow_c12 both=%b got=%b exp=%b", both, obs, 6'b001_0_1_0); end
        step(1);
        tests++; if (obs !== 6'b011_0_1_0) begin fails++; $display("FAIL slow_c13 both=%b got=%b exp=%b", both, obs, 6'b011_0_1_0); end
        step(11);
        tests++; if (obs !== 6'b011_0_1_0) begin fails++; $display("FAIL slow_c24 both=%b got=%b exp=%b", both, obs, 6'b011_0_1_0); end
        step(1);
        tests++; if (obs !== 6'b111_1_0_0) begin fails++; $display("FAIL slow_c25 both=%b got=%b exp=%b", both, obs, 6'b111_1_0_0); end
        do_reset();
    endtask

    task automatic test_drop_ramp_up;
        rapido = 1;
        step(5);
        tests++; if (obs !== 6'b011_0_1_1) begin fails++; $display("FAIL drop_pre got=%b exp=%b", obs, 6'b011_0_1_1); end
        rapido = 0;
        step(1);
`ifdef RAMP_DOWN_SOFT_EN
        tests++; if (obs !== 6'b011_0_1_1) begin fails++; $display("FAIL drop_entry got=%b exp=%b", obs, 6'b011_0_1_1); end
        step(4);
        tests++; if (obs !== 6'b001_0_1_1) begin fails++; $display("FAIL drop_001 got=%b exp=%b", obs, 6'b001_0_1_1); end
        step(4);
        tests++; if (obs !== 6'b000_0_0_1) begin fails++; $display("FAIL drop_idle got=%b exp=%b", obs, 6'b000_0_0_1); end
`else
        tests++; if (obs !== 6'b000_0_0_1) begin fails++; $display("FAIL drop_stop got=%b exp=%b", obs, 6'b000_0_0_1); end
`endif
        do_reset();
    endtask

`ifdef RAMP_DOWN_SOFT_EN
    task automatic test_back_to_back;
        rapido = 1;
        step(9);
        rapido = 0;
        step(5);
        tests++; if (obs !== 6'b011_0_1_1) begin fails++; $display("FAIL b2b_down got=%b exp=%b", obs, 6'b011_0_1_1); end
        rapido = 1;
        step(1);
        tests++; if (obs !== 6'b011_0_1_1) begin fails++; $display("FAIL b2b_up got=%b exp=%b", obs, 6'b011_0_1_1); end
        step(3);
        tests++; if (obs !== 6'b011_0_1_1) begin fails++; $display("FAIL b2b_hold got=%b exp=%b", obs, 6'b011_0_1_1); end
        step(1);
        tests++; if (obs !== 6'b111_1_0_1) begin fails++; $display("FAIL b2b_top got=%b exp=%b", obs, 6'b111_1_0_1); end
        do_reset();
    endtask
`endif

    task automatic test_async_reset;
        rapido = 1;
        step(3);
        tests++; if (obs !== 6'b001_0_1_1) begin fails++; $display("FAIL async_pre got=%b exp=%b", obs, 6'b001_0_1_1); end
        #3 reset = 1;
        #1;
        tests++; if (obs !== 6'b000_0_0_0) begin fails++; $display("FAIL async_now got=%b exp=%b", obs, 6'b000_0_0_0); end
        step(3);
        tests++; if (obs !== 6'b000_0_0_0) begin fails++; $display("FAIL async_hold got=%b exp=%b", obs, 6'b000_0_0_0); end
        reset = 0;
        step(1);
        tests++; if (obs !== 6'b001_0_1_1) begin fails++; $display("FAIL async_restart got=%b exp=%b", obs, 6'b001_0_1_1); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fast();
        do_reset();
        test_slow(1'b0);
        test_slow(1'b1);
        test_drop_ramp_up();
`ifdef RAMP_DOWN_SOFT_EN
        test_back_to_back();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
